fp_vec_reduce_maxmin: RTL and testbench

Streaming floating-point max/min reducer, parametrised in format and lane count. Accepts frames of packed vectors (LANES elements per beat) over a valid/ready handshake. Reduces each frame to a single max or min value plus the element index of the winner (argmax/argmin). Sits after the FP datapath in the pooling and softmax-prep path, and succeeds the two-operand FP32 compare unit.

---
 rtl/fp_cmp_pkg.sv | 22 ++
 rtl/fp_cmp_core.sv | 32 +++
 rtl/fp_vec_reduce_maxmin.sv | 109 ++++++++++
 tb/tb_fp_vec_reduce_maxmin.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the FP max/min reduction path: default format widths,
// FSM encoding, winner record and the canonical quiet NaN.
package fp_cmp_pkg;
  localparam int E_W   = 8;
  localparam int M_W   = 23;
  localparam int K     = 1 + E_W + M_W;
  localparam int IDX_W = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

  typedef struct packed {
    logic [K-1:0]     value;
    logic [IDX_W-1:0] idx;
    logic             nan;
    logic             valid;
  } win_t;

  // Wide enough for any supported format; callers truncate to K bits.
  function automatic logic [127:0] qnan();
    return '1;
  endfunction
endpackage

// File: rtl/fp_cmp_core.sv
// Two-operand winner merge: skips invalid operands, lets the first NaN stick,
// otherwise picks max/min with the lower index winning ties.
module fp_cmp_core #(
  parameter int  KW    = fp_cmp_pkg::K,
  parameter type win_t = fp_cmp_pkg::win_t
) (
  input  win_t a,
  input  win_t b,
  input  logic is_max,
  output win_t y
);
  // Maps sign-magnitude onto an unsigned total order; keeps +0 above -0.
  function automatic logic [KW-1:0] okey(input logic [KW-1:0] v);
    return v[KW-1] ? ~v : {1'b1, v[KW-2:0]};
  endfunction

  logic [KW-1:0] ka, kb;
  logic          a_lo;

  always_comb begin
    ka   = okey(a.value);
    kb   = okey(b.value);
    a_lo = (a.idx <= b.idx);
    y    = a;
    if (!a.valid)               y = b;
    else if (!b.valid)          y = a;
    else if (a.nan && b.nan)    y = a_lo ? a : b;
    else if (a.nan || b.nan)    y = a.nan ? a : b;
    else if (ka == kb)          y = a_lo ? a : b;
    else                        y = ((ka > kb) == is_max) ? a : b;
  end
endmodule

// File: rtl/fp_vec_reduce_maxmin.sv
// Streaming max/min reducer with argmax/argmin: registered lane tree per beat,
// then a running accumulator closed out by a FLUSH/DONE handshake.
module fp_vec_reduce_maxmin
  import fp_cmp_pkg::*;
#(
  parameter int E_WIDTH   = E_W,
  parameter int M_WIDTH   = M_W,
  parameter int LANES     = 4,
  parameter int IDX_WIDTH = IDX_W
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [LANES*(1+E_WIDTH+M_WIDTH)-1:0]   i_data,
  input  logic [LANES-1:0]                       i_keep,
  input  logic                                   i_last,
  input  logic                                   i_is_max,
  output logic                                   o_res_valid,
  input  logic                                   i_res_ready,
  output logic [E_WIDTH+M_WIDTH:0]               o_res,
  output logic [IDX_WIDTH-1:0]                   o_idx,
  output logic                                   o_nan,
  output logic                                   o_empty
);
  localparam int KW = 1 + E_WIDTH + M_WIDTH;

  typedef struct packed {
    logic [KW-1:0]        value;
    logic [IDX_WIDTH-1:0] idx;
    logic                 nan;
    logic                 valid;
  } rec_t;

  state_t               state, state_nx;
  logic                 mode_r, cur_mode, beat_acc, s1_vld, done;
  logic [IDX_WIDTH-1:0] beat_cnt;
  rec_t                 node [2*LANES-1];
  rec_t                 s1_win, acc, acc_m;

  assign o_ready  = (state == IDLE) || (state == ACCUM);
  assign beat_acc = i_valid && o_ready;
  // Mode is live on the first beat and frozen for the rest of the frame.
  assign cur_mode = (state == IDLE) ? i_is_max : mode_r;

  // Heap-ordered tree: leaves at LANES-1.., so left children hold lower lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    logic [KW-1:0] e;
    assign e = i_data[i*KW +: KW];
    assign node[LANES-1+i] = '{
      value: e,
      idx:   beat_cnt * IDX_WIDTH'(LANES) + IDX_WIDTH'(i),
      nan:   i_keep[i] & (&e[KW-2 -: E_WIDTH]) & (|e[M_WIDTH-1:0]),
      valid: i_keep[i]
    };
  end

  for (genvar j = 0; j < LANES-1; j++) begin : g_node
    fp_cmp_core #(.KW(KW), .win_t(rec_t)) u_cmp (
      .a(node[2*j+1]), .b(node[2*j+2]), .is_max(cur_mode), .y(node[j])
    );
  end

  fp_cmp_core #(.KW(KW), .win_t(rec_t)) u_acc_cmp (
    .a(acc), .b(s1_win), .is_max(mode_r), .y(acc_m)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (beat_acc) state_nx = i_last ? FLUSH : ACCUM;
      ACCUM:   if (beat_acc && i_last) state_nx = FLUSH;
      FLUSH:   state_nx = DONE;
      DONE:    if (i_res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      beat_cnt <= '0;
      s1_vld   <= 1'b0;
      s1_win   <= '0;
      acc      <= '0;
    end else begin
      state  <= state_nx;
      s1_vld <= beat_acc;
      if (beat_acc) s1_win <= node[0];
      if (state == IDLE && beat_acc) mode_r <= i_is_max;
      if (state == DONE && i_res_ready) begin
        beat_cnt <= '0;
        acc      <= '0;
      end else begin
        if (beat_acc) beat_cnt <= beat_cnt + IDX_WIDTH'(1);
        if (s1_vld)   acc      <= acc.valid ? acc_m : s1_win;
      end
    end
  end

  assign done        = (state == DONE);
  assign o_res_valid = done;
  assign o_nan       = done && acc.nan;
  assign o_empty     = done && !acc.valid;
  assign o_idx       = (done && acc.valid) ? acc.idx : '0;
  assign o_res       = (!done || !acc.valid) ? '0 :
                       acc.nan ? KW'(qnan()) : acc.value;
endmodule

// File: tb/tb_fp_vec_reduce_maxmin.sv
// Directed bench for fp_vec_reduce_maxmin with a scoreboard fed by a
// linear-scan reference model.
module tb_fp_vec_reduce_maxmin;
  localparam int L = 4;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          i_valid = 0, i_last = 0, i_is_max = 0, i_res_ready = 0;
  logic [127:0]  i_data = '0;
  logic [L-1:0]  i_keep = '0;
  logic          o_ready, o_res_valid, o_nan, o_empty;
  logic [31:0]   o_res;
  logic [15:0]   o_idx;

  always #5 clk = ~clk;

  fp_vec_reduce_maxmin #(.E_WIDTH(8), .M_WIDTH(23), .LANES(L), .IDX_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_keep(i_keep), .i_last(i_last), .i_is_max(i_is_max), .o_res_valid(o_res_valid),
    .i_res_ready(i_res_ready), .o_res(o_res), .o_idx(o_idx), .o_nan(o_nan), .o_empty(o_empty)
  );

  typedef struct {
    logic [31:0] res;
    logic [15:0] idx;
    logic        nan;
    logic        empty;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fd[$];
  logic        fk[$];
  int          nchk = 0, nerr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strict a > b in sign-magnitude terms.
  function automatic bit gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic exp_t model(input bit is_max);
    exp_t e;
    bit found = 0, nanf = 0, isn;
    logic [31:0] best = '0;
    int bi = 0, ni = 0;
    for (int k = 0; k < fd.size(); k++) begin
      if (!fk[k]) continue;
      isn = (&fd[k][30:23]) && (|fd[k][22:0]);
      if (isn) begin
        if (!nanf) begin nanf = 1; ni = k; end
      end else if (!found || (is_max ? gt(fd[k], best) : gt(best, fd[k]))) begin
        found = 1; best = fd[k]; bi = k;
      end
    end
    e.empty = !(found || nanf);
    e.nan   = nanf;
    e.res   = nanf ? 32'hFFFF_FFFF : (found ? best : 32'h0);
    e.idx   = nanf ? 16'(ni) : (found ? 16'(bi) : 16'h0);
    return e;
  endfunction

  task automatic add_beat(input logic [31:0] d0, d1, d2, d3, input logic [3:0] k);
    fd.push_back(d0); fd.push_back(d1); fd.push_back(d2); fd.push_back(d3);
    for (int i = 0; i < 4; i++) fk.push_back(k[i]);
  endtask

  task automatic drive_beat(input logic [127:0] d, input logic [3:0] k, input bit last, input bit mode);
    int n = 0;
    @(negedge clk);
    while (!o_ready && n < 20) begin @(negedge clk); n++; end
    if (!o_ready) begin
      nchk++; nerr++;
      $error("FAIL ready_timeout: observed o_ready=0 expected 1 within 20 cycles");
    end
    i_valid = 1; i_data = d; i_keep = k; i_last = last; i_is_max = mode;
    @(posedge clk);
    #1 i_valid = 0; i_last = 0;
  endtask

  // Sends the staged frame; later beats flip i_is_max, which must be ignored.
  task automatic send_frame(input bit mode);
    int nb = fd.size() / 4;
    sb.push_back(model(mode));
    for (int b = 0; b < nb; b++)
      drive_beat({fd[4*b+3], fd[4*b+2], fd[4*b+1], fd[4*b]},
                 {fk[4*b+3], fk[4*b+2], fk[4*b+1], fk[4*b]},
                 b == nb-1, (b == 0) ? mode : ~mode);
    fd.delete(); fk.delete();
  endtask

  task automatic get_result(input string tag, input int hold);
    exp_t e;
    int n = 1;
    bit stable = 1;
    @(negedge clk);
    while (!o_res_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, "_latency"}, n, 2);
    if (sb.size() == 0) begin
      nchk++; nerr++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, "_res"}, o_res, e.res);
    check({tag, "_idx"}, o_idx, e.idx);
    check({tag, "_nan"}, o_nan, e.nan);
    check({tag, "_empty"}, o_empty, e.empty);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (o_res_valid !== 1 || o_ready !== 0 || o_res !== e.res || o_idx !== e.idx ||
            o_nan !== e.nan || o_empty !== e.empty) stable = 0;
      end
      check({tag, "_hold_stable"}, stable, 1);
    end
    i_res_ready = 1;
    @(posedge clk);
    #1 i_res_ready = 0;
    @(negedge clk);
    check({tag, "_free_ready"}, o_ready, 1);
    check({tag, "_free_valid"}, o_res_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", o_res_valid, 0);
    check("rst_res", o_res, 0);
    check("rst_idx", o_idx, 0);
    check("rst_nan", o_nan, 0);
    check("rst_empty", o_empty, 0);
    rstn = 1;
    @(negedge clk);
    check("rst_ready", o_ready, 1);

    // Max, single beat
    add_beat(32'h3F80_0000, 32'hC040_0000, 32'h4000_0000, 32'h0000_0000, 4'b1111);
    send_frame(1'b1);
    get_result("max1", 0);

    // Min, two beats, tie on 1.0 resolved to lower index
    add_beat(32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 4'b1111);
    add_beat(32'h3F80_0000, 32'h40A0_0000, 32'h40A0_0000, 32'h40A0_0000, 4'b1111);
    send_frame(1'b0);
    get_result("min2", 0);

    // Signed zeros with masked +inf
    add_beat(32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h7F80_0000, 4'b0011);
    send_frame(1'b1);
    get_result("zero_keep", 0);

    // First NaN at index 5 beats +inf; later negative NaN at 7
    add_beat(32'h3F80_0000, 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 4'b1111);
    add_beat(32'h4040_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'hFF80_0001, 4'b1111);
    send_frame(1'b1);
    get_result("nan", 0);

    // Empty frame with masked NaN, result held for 10 cycles
    add_beat(32'h7FC0_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000);
    add_beat(32'h4080_0000, 32'hC000_0000, 32'h7FC0_0000, 32'h0000_0000, 4'b0000);
    send_frame(1'b1);
    get_result("empty_hold", 10);

    // Partial keep, three beats, min mode with negative values
    add_beat(32'h4080_0000, 32'hC100_0000, 32'h4000_0000, 32'hC120_0000, 4'b0101);
    add_beat(32'hC040_0000, 32'h7FC0_0000, 32'h4000_0000, 32'hC080_0000, 4'b1001);
    add_beat(32'hFF80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0010);
    send_frame(1'b0);
    get_result("partial", 0);

    // Random frame
    for (int b = 0; b < 4; b++)
      add_beat($urandom, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)));
    send_frame(1'($urandom_range(0, 1)));
    get_result("rand", 0);

    // Reset mid-frame after three beats
    for (int b = 0; b < 3; b++)
      drive_beat({4{32'hBF80_0000}}, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 0;
    @(negedge clk);
    check("midrst_valid", o_res_valid, 0);
    rstn = 1;
    @(negedge clk);
    check("midrst_ready", o_ready, 1);
    check("midrst_valid_after", o_res_valid, 0);
    add_beat(32'h4080_0000, 32'h4040_0000, 32'h40A0_0000, 32'h40C0_0000, 4'b1111);
    send_frame(1'b0);
    get_result("post_rst", 0);

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
